// File: rtl/nios_system_onchip_memory_stream_writer.sv
// Packs an 8-bit byte stream little-endian into 32-bit words and issues one memory write per word.
// Optional framing: define ONCHIP_STREAM_PACKET_EN to add snk_startofpacket/snk_endofpacket inputs.
module nios_system_onchip_memory_stream_writer #(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
`ifdef ONCHIP_STREAM_PACKET_EN
    input  logic              snk_startofpacket,
    input  logic              snk_endofpacket,
`endif
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic [ADDR_W:0]   words_written,
    output logic              wrap,
    output logic              busy
);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(BASE_ADDR);

    state_t            state_reg, state_next;
    logic [1:0]        lane_reg, lane_next;
    logic [31:0]       assembly_reg, assembly_next;
    logic [3:0]        be_acc_reg, be_acc_next;
    logic              wr_reg, wr_next;
    logic [31:0]       wr_data_reg, wr_data_next;
    logic [3:0]        wr_be_reg, wr_be_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W:0]   count_reg, count_next;

    logic              sop, eop, accept, restart;
    logic [1:0]        lane_base;
    logic [31:0]       asm_base, asm_word;
    logic [3:0]        be_base, be_word;

`ifdef ONCHIP_STREAM_PACKET_EN
    assign sop = snk_startofpacket;
    assign eop = snk_endofpacket;
`else
    assign sop = 1'b0;
    assign eop = 1'b0;
`endif

    assign snk_ready = (state_reg == S_RUN) && !start;
    assign accept    = snk_valid && snk_ready;
    assign restart   = accept && sop;

    // A start-of-packet byte discards the partial word and lands in lane 0.
    always_comb begin
        lane_base = lane_reg;
        asm_base  = assembly_reg;
        be_base   = be_acc_reg;
        if (restart) begin
            lane_base = 2'd0;
            asm_base  = '0;
            be_base   = '0;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic hit;
        assign hit                   = accept && (lane_base == 2'(gi));
        assign asm_word[8*gi +: 8]   = hit ? snk_data : asm_base[8*gi +: 8];
        assign be_word[gi]           = be_base[gi] | hit;
    end

    always_comb begin
        state_next    = state_reg;
        lane_next     = lane_reg;
        assembly_next = assembly_reg;
        be_acc_next   = be_acc_reg;
        wr_next       = 1'b0;
        wr_data_next  = wr_data_reg;
        wr_be_next    = wr_be_reg;
        addr_next     = addr_reg;
        count_next    = count_reg;

        // The in-flight write retires at the end of its cycle; start/SOP may override the address.
        if (wr_reg) begin
            addr_next = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
            if (count_reg != '1)
                count_next = count_reg + 1'b1;
        end

        if (start) begin
            state_next    = S_RUN;
            lane_next     = '0;
            assembly_next = '0;
            be_acc_next   = '0;
            addr_next     = start_addr;
            count_next    = '0;
        end else if (state_reg == S_FLUSH) begin
            wr_next       = 1'b1;
            wr_data_next  = assembly_reg;
            wr_be_next    = be_acc_reg;
            lane_next     = '0;
            assembly_next = '0;
            be_acc_next   = '0;
            state_next    = S_RUN;
        end else begin
            if (restart)
                addr_next = start_addr;
            if (accept && (lane_base == 2'd3 || eop)) begin
                wr_next       = 1'b1;
                wr_data_next  = asm_word;
                wr_be_next    = be_word;
                lane_next     = '0;
                assembly_next = '0;
                be_acc_next   = '0;
            end else begin
                if (accept) begin
                    lane_next     = lane_base + 1'b1;
                    assembly_next = asm_word;
                    be_acc_next   = be_word;
                end
                if (flush && lane_reg != 2'd0)
                    state_next = S_FLUSH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_RUN;
            lane_reg     <= '0;
            assembly_reg <= '0;
            be_acc_reg   <= '0;
            wr_reg       <= 1'b0;
            wr_data_reg  <= '0;
            wr_be_reg    <= '0;
            addr_reg     <= RESET_ADDR;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            lane_reg     <= lane_next;
            assembly_reg <= assembly_next;
            be_acc_reg   <= be_acc_next;
            wr_reg       <= wr_next;
            wr_data_reg  <= wr_data_next;
            wr_be_reg    <= wr_be_next;
            addr_reg     <= addr_next;
            count_reg    <= count_next;
        end
    end

    assign mem_address    = addr_reg;
    assign mem_byteenable = wr_be_reg;
    assign mem_chipselect = wr_reg;
    assign mem_write      = wr_reg;
    assign mem_writedata  = wr_data_reg;
    assign mem_clken      = 1'b1;
    assign words_written  = count_reg;
    assign wrap           = wr_reg && (addr_reg == LAST_ADDR);
    assign busy           = (lane_reg != 2'd0) || wr_reg || (state_reg == S_FLUSH);

endmodule

// File: tb/tb_nios_system_onchip_memory_stream_writer.sv
// Self-checking bench: byte-queue reference model compared every cycle, plus literal scenario checks.
module tb_nios_system_onchip_memory_stream_writer;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;
    localparam int SAT    = (1 << (ADDR_W + 1)) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        snk_data = '0;
    logic              snk_valid = 1'b0;
    logic              snk_ready;
    logic              sop_in = 1'b0;
    logic              eop_in = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              flush = 1'b0;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [ADDR_W:0]   words_written;
    logic              wrap;
    logic              busy;

    nios_system_onchip_memory_stream_writer #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .snk_data(snk_data),
        .snk_valid(snk_valid),
        .snk_ready(snk_ready),
`ifdef ONCHIP_STREAM_PACKET_EN
        .snk_startofpacket(sop_in),
        .snk_endofpacket(eop_in),
`endif
        .start(start),
        .start_addr(start_addr),
        .flush(flush),
        .mem_address(mem_address),
        .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect),
        .mem_write(mem_write),
        .mem_writedata(mem_writedata),
        .mem_clken(mem_clken),
        .words_written(words_written),
        .wrap(wrap),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit quiet  = 1'b0;

    // Reference model: bytes waiting to be packed, pending write, address and count.
    byte unsigned m_bytes[$];
    bit           m_in_flush;
    bit           m_wr;
    int           m_addr;
    int           m_count;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wbe;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_bytes.delete();
        m_in_flush = 1'b0;
        m_wr       = 1'b0;
        m_addr     = 0;
        m_count    = 0;
        m_wdata    = '0;
        m_wbe      = '0;
    endtask

    task automatic model_compare();
        check("snk_ready", 32'(snk_ready), 32'(!m_in_flush && !start));
        check("mem_write", 32'(mem_write), 32'(m_wr));
        check("mem_chipselect", 32'(mem_chipselect), 32'(m_wr));
        check("mem_clken", 32'(mem_clken), 32'd1);
        check("mem_address", 32'(mem_address), 32'(m_addr));
        check("words_written", 32'(words_written), 32'(m_count));
        check("wrap", 32'(wrap), 32'(m_wr && m_addr == DEPTH - 1));
        check("busy", 32'(busy), 32'(m_bytes.size() != 0 || m_wr || m_in_flush));
        if (m_wr) begin
            check("mem_writedata", mem_writedata, m_wdata);
            check("mem_byteenable", 32'(mem_byteenable), 32'(m_wbe));
            if (!quiet)
                $display("write addr=%0d data=%08h be=%h wrap=%0b", m_addr, m_wdata, m_wbe, wrap);
        end
    endtask

    task automatic model_step();
        bit ready, acc, issue;
        int had;
        ready = !m_in_flush && !start;
        acc   = snk_valid && ready;
        issue = 1'b0;
        if (m_wr) begin
            m_addr = (m_addr == DEPTH - 1) ? 0 : m_addr + 1;
            if (m_count < SAT) m_count++;
        end
        if (start) begin
            m_bytes.delete();
            m_in_flush = 1'b0;
            m_addr     = int'(start_addr);
            m_count    = 0;
        end else if (m_in_flush) begin
            issue      = 1'b1;
            m_in_flush = 1'b0;
        end else begin
            had = m_bytes.size();
            if (acc && sop_in) begin
                m_bytes.delete();
                m_addr = int'(start_addr);
            end
            if (acc) m_bytes.push_back(snk_data);
            if (acc && (m_bytes.size() == 4 || eop_in)) issue = 1'b1;
            else if (flush && had != 0) m_in_flush = 1'b1;
        end
        m_wr = issue;
        if (issue) begin
            m_wdata = '0;
            m_wbe   = '0;
            foreach (m_bytes[i]) begin
                m_wdata = m_wdata | (32'(m_bytes[i]) << (8 * i));
                m_wbe[i] = 1'b1;
            end
            m_bytes.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) model_reset();
        model_compare();
        if (reset_n) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        snk_valid = 1'b0;
        flush     = 1'b0;
        start     = 1'b0;
        sop_in    = 1'b0;
        eop_in    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic f);
        snk_valid = 1'b1;
        snk_data  = b;
        flush     = f;
        tick();
        idle();
    endtask

    task automatic check_reset_values();
        check("rst snk_ready", 32'(snk_ready), 32'd1);
        check("rst mem_write", 32'(mem_write), 32'd0);
        check("rst mem_chipselect", 32'(mem_chipselect), 32'd0);
        check("rst mem_byteenable", 32'(mem_byteenable), 32'd0);
        check("rst mem_writedata", mem_writedata, 32'd0);
        check("rst mem_address", 32'(mem_address), 32'd0);
        check("rst words_written", 32'(words_written), 32'd0);
        check("rst wrap", 32'(wrap), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        reset_n = 1'b1;
    endtask

    initial begin
        // T1: one full word
        do_reset();
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        check("t1 write", 32'(mem_write), 32'd1);
        check("t1 data", mem_writedata, 32'h44332211);
        check("t1 be", 32'(mem_byteenable), 32'hF);
        check("t1 addr", 32'(mem_address), 32'd0);
        tick();
        check("t1 addr after", 32'(mem_address), 32'd1);
        check("t1 count", 32'(words_written), 32'd1);

        // T2: partial word flush
        do_reset();
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
        flush = 1'b1; tick(); idle();
        check("t2 ready low", 32'(snk_ready), 32'd0);
        check("t2 no write yet", 32'(mem_write), 32'd0);
        tick();
        check("t2 ready back", 32'(snk_ready), 32'd1);
        check("t2 write", 32'(mem_write), 32'd1);
        check("t2 data", mem_writedata, 32'h00CCBBAA);
        check("t2 be", 32'(mem_byteenable), 32'h7);
        tick();
        check("t2 count", 32'(words_written), 32'd1);

        // T3: wrap at the top of memory
        do_reset();
        start = 1'b1; start_addr = 12'd4095; tick(); idle();
        check("t3 start addr", 32'(mem_address), 32'd4095);
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        check("t3 write hi", 32'(mem_write), 32'd1);
        check("t3 wrap", 32'(wrap), 32'd1);
        check("t3 data hi", mem_writedata, 32'h04030201);
        for (int i = 5; i <= 8; i++) send(8'(i), 1'b0);
        check("t3 write lo", 32'(mem_write), 32'd1);
        check("t3 addr lo", 32'(mem_address), 32'd0);
        check("t3 no wrap", 32'(wrap), 32'd0);
        tick();
        check("t3 addr after", 32'(mem_address), 32'd1);
        check("t3 count", 32'(words_written), 32'd2);

        // T4: 4th byte with flush, then flush with empty lane
        do_reset();
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
        check("t4 write", 32'(mem_write), 32'd1);
        check("t4 be", 32'(mem_byteenable), 32'hF);
        tick();
        check("t4 single write", 32'(mem_write), 32'd0);
        check("t4 ready", 32'(snk_ready), 32'd1);
        flush = 1'b1; tick(); idle();
        check("t4 empty flush ready", 32'(snk_ready), 32'd1);
        tick();
        check("t4 empty flush no write", 32'(mem_write), 32'd0);
        check("t4 count", 32'(words_written), 32'd1);

        // T5: start drops partial word, then reset mid-word
        do_reset();
        send(8'h55, 1'b0); send(8'h66, 1'b0);
        start = 1'b1; start_addr = 12'd16; snk_valid = 1'b1; snk_data = 8'h77;
        #1;
        check("t5 ready in start", 32'(snk_ready), 32'd0);
        tick(); idle();
        check("t5 busy", 32'(busy), 32'd0);
        check("t5 addr", 32'(mem_address), 32'd16);
        send(8'hA0, 1'b0); send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
        check("t5 write", 32'(mem_write), 32'd1);
        check("t5 write addr", 32'(mem_address), 32'd16);
        check("t5 data", mem_writedata, 32'hA3A2A1A0);
        send(8'hB0, 1'b0); send(8'hB1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

`ifdef ONCHIP_STREAM_PACKET_EN
        // T6: two-byte packet
        do_reset();
        start_addr = 12'd100;
        sop_in = 1'b1; send(8'h01, 1'b0);
        eop_in = 1'b1; send(8'h02, 1'b0);
        check("t6 write", 32'(mem_write), 32'd1);
        check("t6 be", 32'(mem_byteenable), 32'h3);
        check("t6 data", mem_writedata, 32'h00000201);
        check("t6 addr", 32'(mem_address), 32'd100);
`endif

        // Randomized traffic checked cycle by cycle against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            snk_valid  = ($urandom_range(0, 9) < 7);
            snk_data   = 8'($urandom);
            flush      = ($urandom_range(0, 19) == 0);
            start      = ($urandom_range(0, 59) == 0);
            start_addr = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(4090, 4095)) : 12'($urandom);
`ifdef ONCHIP_STREAM_PACKET_EN
            sop_in     = ($urandom_range(0, 29) == 0);
            eop_in     = ($urandom_range(0, 9) == 0);
`endif
            tick();
        end
        idle();
        tick();

        // Saturation of words_written
        do_reset();
        quiet     = 1'b1;
        snk_valid = 1'b1;
        for (int i = 0; i < (SAT + 4) * 4; i++) begin
            snk_data = 8'($urandom);
            tick();
        end
        idle();
        repeat (2) tick();
        quiet = 1'b0;
        check("saturated count", 32'(words_written), 32'(SAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
